aes128_ctr_stream: RTL and testbench

Counter-mode (CTR) streaming front end for the combinational `aes128` core. It holds the key and a 128-bit counter block, and feeds the counter to one `aes128` instance as plaintext. It XORs the resulting keystream with incoming 128-bit data blocks and presents the result through a registered valid/ready output. Encryption and decryption are the same operation.

---
 rtl/aes128_ctr_stream.sv | 195 +++++++++++++++++++
 tb/tb_aes128_ctr_stream.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_ctr_stream.sv
// AES-128 counter-mode stream front end with its combinational AES-128 core.
// Optional macro AES_CTR_WRAP_GUARD_EN: halt input after a counter wrap until the next key_load.

module aes128 (
  input  logic [127:0] key,
  input  logic [127:0] pt,
  output logic [127:0] ct
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box from the field inverse x^254 followed by the affine map; 0 maps to 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 7; i++) r = gmul(gmul(r, r), x);
    r = gmul(r, r);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 4; i++) o[32*i +: 32] = sub_word(s[32*i +: 32]);
    return o;
  endfunction

  // Byte i of the state sits at bits [127-8i -: 8], column-major (i = row + 4*col).
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] rk, st;
    logic [7:0]   rc;
    rk = k;
    st = p ^ k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rk = next_round_key(rk, rc);
      st = shift_rows(sub_bytes(st));
      if (r < 10) st = mix_columns(st);
      st = st ^ rk;
      rc = xtime(rc);
    end
    return st;
  endfunction

  assign ct = aes_encrypt(key, pt);

endmodule

module aes128_ctr_stream #(
  parameter int CTR_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         ctr_wrap
);

  // Ones over the incrementing low field; the nonce bits above it never change.
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_W);

  logic [127:0] key_q, key_d, ctr_q, ctr_d, out_data_q, out_data_d, keystream;
  logic         keyed_q, keyed_d, ctr_wrap_q, ctr_wrap_d;
  logic         out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic         halt, accept;

  aes128 u_aes (
    .key (key_q),
    .pt  (ctr_q),
    .ct  (keystream)
  );

`ifdef AES_CTR_WRAP_GUARD_EN
  assign halt = ctr_wrap_q;
`else
  assign halt = 1'b0;
`endif

  assign in_ready = keyed_q && !key_load && (!out_valid_q || out_ready) && !halt;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave a latch behind.
    key_d      = key_q;
    ctr_d      = ctr_q;
    keyed_d    = keyed_q;
    ctr_wrap_d = ctr_wrap_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (key_load) begin
      key_d      = key;
      ctr_d      = iv;
      keyed_d    = 1'b1;
      ctr_wrap_d = 1'b0;
    end else if (accept) begin
      ctr_d = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
      if ((ctr_q & CTR_MASK) == CTR_MASK) ctr_wrap_d = 1'b1;
    end

    // key_load blocks accept, so a pending block keeps its old-key data.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ keystream;
      out_last_d  = in_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q       <= '0;
      ctr_q       <= '0;
      keyed_q     <= 1'b0;
      ctr_wrap_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      key_q       <= key_d;
      ctr_q       <= ctr_d;
      keyed_q     <= keyed_d;
      ctr_wrap_q  <= ctr_wrap_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign ctr_wrap  = ctr_wrap_q;

endmodule

// File: tb/tb_aes128_ctr_stream.sv
// Self-checking bench for aes128_ctr_stream: known-answer vectors plus a randomized
// stream scored against a table-driven AES-128 reference and a transaction queue.

module tb_aes128_ctr_stream;

  localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C0  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] IV2 = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;

`ifdef AES_CTR_WRAP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic         clk, rst_n, key_load, in_valid, in_ready, in_last;
  logic         out_valid, out_ready, out_last, ctr_wrap;
  logic [127:0] key, iv, in_data, out_data;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } blk_t;

  blk_t         exp_q[$];
  logic [7:0]   sbox_t [256];
  logic [127:0] m_key, m_ctr;
  logic         m_keyed, m_wrap;

  aes128_ctr_stream #(.CTR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_load  (key_load),
    .key       (key),
    .iv        (iv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .ctr_wrap  (ctr_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference AES-128 (table S-box, byte-array state) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) begin
      tmp  = w[i/4];
      s[i] = p[127-8*i -: 8] ^ tmp[31-8*(i%4) -: 8];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (rnd < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) begin
        tmp  = w[4*rnd + i/4];
        s[i] = s[i] ^ tmp[31-8*(i%4) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic model_in_ready();
    return m_keyed && !key_load && (exp_q.size() == 0 || out_ready) && !(GUARD && m_wrap);
  endfunction

  // One clock: called just after a falling edge with inputs driven; returns after the next falling edge.
  task automatic tick();
    logic acc, drain, kl;
    blk_t b;
    #1;
    acc   = in_valid && in_ready;
    drain = (exp_q.size() != 0) && out_ready;
    kl    = key_load;
    b     = '0;
    if (acc) begin
      b.data = in_data ^ aes_ref(m_key, m_ctr);
      b.last = in_last;
    end
    @(posedge clk);
    if (drain) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(b);
      if (m_ctr[31:0] == 32'hffffffff) m_wrap = 1'b1;
      m_ctr[31:0] = m_ctr[31:0] + 32'd1;
    end
    if (kl) begin
      m_key = key; m_ctr = iv; m_keyed = 1'b1; m_wrap = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic load_key(input logic [127:0] k, input logic [127:0] v);
    key_load = 1'b1;
    key      = k;
    iv       = v;
    tick();
    key_load = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    checks++; if (ctr_wrap !== 1'b0) begin errors++; $display("FAIL reset_ctr_wrap got=%b exp=0", ctr_wrap); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_data   = rand128();
    out_ready = 1'b1;
    repeat (3) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL unkeyed_in_ready got=%b exp=0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unkeyed_out_valid got=%b exp=0", out_valid); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_fips();
    out_ready = 1'b1;
    load_key(K, IV1);
    in_valid = 1'b1; in_data = 128'h0; in_last = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fips_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fips_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== C0) begin errors++; $display("FAIL fips_out_data got=%h exp=%h", out_data, C0); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL fips_out_last got=%b exp=1", out_last); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fips_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    load_key(K, IV2);
    in_valid = 1'b1; in_data = P1; in_last = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_data !== C1) begin errors++; $display("FAIL b2b_block0 got=%h exp=%h", out_data, C1); end
    in_data = P2; in_last = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_data !== C2) begin errors++; $display("FAIL b2b_block1 got=%h exp=%h", out_data, C2); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL b2b_last got=%b exp=1", out_last); end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    load_key(K, IV2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = P1; in_last = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got=%b exp=1", in_ready); end
    tick();
    in_data = P2; in_last = 1'b1;
    repeat (4) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got=%b exp=0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== C1) begin errors++; $display("FAIL bp_hold_data got=%h exp=%h", out_data, C1); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL bp_hold_last got=%b exp=0", out_last); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== C2) begin errors++; $display("FAIL bp_next_data got=%h exp=%h", out_data, C2); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL bp_next_last got=%b exp=1", out_last); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_wrap();
    logic [127:0] iv3, d1, d2, e1, e2;
    iv3 = rand128();
    iv3[31:0] = 32'hffffffff;
    d1 = rand128();
    d2 = rand128();
    e1 = d1 ^ aes_ref(K, iv3);
    e2 = d2 ^ aes_ref(K, {iv3[127:32], 32'h0});
    out_ready = 1'b1;
    load_key(K, iv3);
    in_valid = 1'b1; in_data = d1; in_last = 1'b0;
    tick();
    checks++; if (out_data !== e1) begin errors++; $display("FAIL wrap_first_data got=%h exp=%h", out_data, e1); end
    checks++; if (ctr_wrap !== 1'b1) begin errors++; $display("FAIL wrap_flag got=%b exp=1", ctr_wrap); end
    in_data = d2; in_last = 1'b1;
    #1;
`ifdef AES_CTR_WRAP_GUARD_EN
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wrap_halt_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_halt_valid got=%b exp=0", out_valid); end
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wrap_halt_hold got=%b exp=0", in_ready); end
`else
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL wrap_cont_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_data !== e2) begin errors++; $display("FAIL wrap_second_data got=%h exp=%h", out_data, e2); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL wrap_second_last got=%b exp=1", out_last); end
`endif
    checks++; if (ctr_wrap !== 1'b1) begin errors++; $display("FAIL wrap_sticky got=%b exp=1", ctr_wrap); end
    in_valid = 1'b0;
    load_key(K, IV1);
    checks++; if (ctr_wrap !== 1'b0) begin errors++; $display("FAIL wrap_clear got=%b exp=0", ctr_wrap); end
    tick();
  endtask

  task automatic test_key_load_pending();
    logic [127:0] k2, iv4, d, e;
    k2  = rand128();
    iv4 = rand128();
    d   = rand128();
    e   = d ^ aes_ref(k2, iv4);
    out_ready = 1'b1;
    load_key(K, IV2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = P1; in_last = 1'b1;
    tick();
    key_load = 1'b1; key = k2; iv = iv4;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL kl_in_ready got=%b exp=0", in_ready); end
    tick();
    key_load = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL kl_pending_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== C1) begin errors++; $display("FAIL kl_pending_data got=%h exp=%h", out_data, C1); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL kl_pending_last got=%b exp=1", out_last); end
    in_data = d; in_last = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL kl_next_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_data !== e) begin errors++; $display("FAIL kl_new_key_data got=%h exp=%h", out_data, e); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL kl_new_key_last got=%b exp=0", out_last); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    load_key(rand128(), rand128());
    tick();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        key_load = 1'b1; key = rand128(); iv = rand128();
      end else begin
        key_load = 1'b0;
      end
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = rand128();
      in_last   = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 2) != 0;
      #1;
      checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", n, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        checks++; if (out_data !== exp_q[0].data) begin errors++; $display("FAIL rand_out_data cyc=%0d got=%h exp=%h", n, out_data, exp_q[0].data); end
        checks++; if (out_last !== exp_q[0].last) begin errors++; $display("FAIL rand_out_last cyc=%0d got=%b exp=%b", n, out_last, exp_q[0].last); end
      end
      checks++; if (in_ready !== model_in_ready()) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", n, in_ready, model_in_ready()); end
      tick();
    end
    key_load  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_final_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    load_key(rand128(), rand128());
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = rand128(); in_last = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending got=%b exp=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL rmid_out_data got=%h exp=0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rmid_out_last got=%b exp=0", out_last); end
    checks++; if (ctr_wrap !== 1'b0) begin errors++; $display("FAIL rmid_ctr_wrap got=%b exp=0", ctr_wrap); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
    exp_q.delete();
    m_keyed = 1'b0;
    m_wrap  = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_unkeyed_ready got=%b exp=0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_unkeyed_valid got=%b exp=0", out_valid); end
    end
    in_valid = 1'b0;
    load_key(K, IV1);
    in_valid = 1'b1; in_data = 128'h0; in_last = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_rekey_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_data !== C0) begin errors++; $display("FAIL rmid_rekey_data got=%h exp=%h", out_data, C0); end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    build_sbox();
    rst_n = 1'b1; key_load = 1'b0; key = '0; iv = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    m_key = '0; m_ctr = '0; m_keyed = 1'b0; m_wrap = 1'b0;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_fips();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_key_load_pending();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
